// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between a variable-latency instruction memory and the core.
// Owns the fetch PC and keeps at most one word request outstanding on the req/ack port.
// Returned words are queued with their PCs in a prefetch FIFO and handed to the core over
// valid/ready. A redirect flushes the FIFO and drops any response still in flight.
// Optional feature macro: IFU_PERF_CNT_EN adds the stall_cycles and flush_count counters.
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam int unsigned PW        = $clog2(DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
    localparam logic [31:0] Nop       = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDiscard
    } state_e;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;

    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          ack_fire;
    logic          push;
    logic          pop;
    logic          can_issue;
    logic [31:0]   redirect_target;
    logic [31:0]   pc_plus4;
    logic [31:0]   discard_target;

    // Handshake decode and FIFO occupancy after this cycle's push/pop/flush.
    always_comb begin
        ack_fire        = imem_req & imem_ack;
        pop             = instr_valid & instr_ready;
        // Only a live request in StReq delivers data; a redirect kills same-cycle data.
        push            = ack_fire & (state_q == StReq) & ~redirect_valid;
        redirect_target = redirect_pc & ~32'd3;
        pc_plus4        = fetch_pc_q + 32'd4;
        // In StDiscard the last redirect wins, including one that lands with the ack.
        discard_target  = redirect_valid ? redirect_target : fetch_pc_q;
        count_d         = count_q;
        if (redirect_valid) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        can_issue = (count_d < FullCnt);
    end

    // Fetch FSM with registered request outputs; holds req/addr stable until ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_target;
                    end else if (can_issue) begin
                        state_q   <= StReq;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc_q;
                    end
                end
                StReq: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_target;
                        if (ack_fire) begin
                            // Data dropped; the flushed FIFO always has room.
                            state_q   <= can_issue ? StReq : StIdle;
                            imem_req  <= can_issue;
                            imem_addr <= redirect_target;
                        end else begin
                            // Request must stay asserted until its ack drains it.
                            state_q <= StDiscard;
                        end
                    end else if (ack_fire) begin
                        fetch_pc_q <= pc_plus4;
                        if (can_issue) begin
                            imem_addr <= pc_plus4;
                        end else begin
                            state_q  <= StIdle;
                            imem_req <= 1'b0;
                        end
                    end
                end
                StDiscard: begin
                    fetch_pc_q <= discard_target;
                    if (ack_fire) begin
                        state_q   <= can_issue ? StReq : StIdle;
                        imem_req  <= can_issue;
                        imem_addr <= discard_target;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    // FIFO storage; contents are don't-care until marked valid by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]   <= fetch_pc_q;
            fifo_data[wr_ptr_q] <= imem_rdata;
        end
    end

    // Core-facing head, derived only from registered FIFO state.
    always_comb begin
        instr_valid = (count_q != '0);
        instr       = instr_valid ? fifo_data[rd_ptr_q] : Nop;
        instr_pc    = instr_valid ? fifo_pc[rd_ptr_q] : 32'h0;
    end

`ifdef IFU_PERF_CNT_EN
    // Performance counters: cycles with nothing to offer, and redirect cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'h0;
            flush_count  <= 32'h0;
        end else begin
            if (!instr_valid) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_valid) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run checked against a
// queue-based transaction model of the fetch stream.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int tests = 0;
    int fails = 0;

    // Memory responder controls: fixed latency (-1 = never ack) or random per request.
    int mem_lat  = 0;
    bit mem_rand = 0;
    int cur_lat  = 0;
    int wait_cnt = 0;

    // Reference model state for the randomized run.
    bit          mon_en = 0;
    logic [31:0] mq[$];
    logic [31:0] exp_addr;
    bit          dead;
    bit          prev_hold;
    logic [31:0] prev_addr;
    int          pops;

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // Drive point: just after the falling edge, once the responder has settled.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Instruction memory: ack after cur_lat waiting cycles, data is a hash of the address.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!imem_req) begin
                wait_cnt = 0;
                imem_ack = mem_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
            end else begin
                if (wait_cnt == 0) cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
                imem_ack = (cur_lat >= 0) && (wait_cnt >= cur_lat);
                wait_cnt = imem_ack ? 0 : wait_cnt + 1;
            end
            imem_rdata = memf(imem_addr);
        end
    end

    // Transaction model: queue of delivered PCs, expected request address, dead-request flag.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en && rst_n) begin
                tests++;
                if (instr_valid !== (mq.size() != 0)) begin
                    fails++;
                    $display("FAIL model_valid: instr_valid=%b, want %b", instr_valid,
                             mq.size() != 0);
                end else if (instr_valid) begin
                    tests++;
                    if (instr_pc !== mq[0] || instr !== memf(mq[0])) begin
                        fails++;
                        $display("FAIL model_head: pc=%h instr=%h, want pc=%h instr=%h",
                                 instr_pc, instr, mq[0], memf(mq[0]));
                    end
                end else begin
                    tests++;
                    if (instr !== NOP || instr_pc !== 32'h0) begin
                        fails++;
                        $display("FAIL model_empty: pc=%h instr=%h, want 0 %h", instr_pc,
                                 instr, NOP);
                    end
                end
                if (imem_req && !dead) begin
                    tests++;
                    if (imem_addr !== exp_addr) begin
                        fails++;
                        $display("FAIL model_addr: imem_addr=%h, want %h", imem_addr, exp_addr);
                    end
                end
                if (prev_hold) begin
                    tests++;
                    if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                        fails++;
                        $display("FAIL model_hold: req=%b addr=%h, want 1 %h", imem_req,
                                 imem_addr, prev_addr);
                    end
                end
                prev_hold = imem_req && !imem_ack;
                prev_addr = imem_addr;
                if (instr_valid && instr_ready && mq.size() != 0) begin
                    void'(mq.pop_front());
                    pops++;
                end
                if (redirect_valid) begin
                    mq.delete();
                    dead     = imem_req && !imem_ack;
                    exp_addr = redirect_pc & ~32'd3;
                end else if (imem_req && imem_ack) begin
                    if (dead) begin
                        dead = 1'b0;
                    end else begin
                        mq.push_back(exp_addr);
                        exp_addr = exp_addr + 32'd4;
                    end
                end
                tests++;
                if (mq.size() > DEPTH) begin
                    fails++;
                    $display("FAIL model_overflow: entries=%0d, want <= %0d", mq.size(), DEPTH);
                end
            end
        end
    end

    task automatic test_reset();
        cyc();
        tests++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
            fails++;
            $display("FAIL reset_req: req=%b addr=%h, want 0 %h", imem_req, imem_addr, RESET_PC);
        end
        tests++;
        if (instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_head: valid=%b instr=%h pc=%h, want 0 %h 0", instr_valid,
                     instr, instr_pc, NOP);
        end
    endtask

    task automatic test_zero_wait();
        mem_rand = 0; mem_lat = 0; instr_ready = 1'b1;
        do_reset();
        cyc();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_wait_first: req=%b addr=%h valid=%b, want 1 %h 0", imem_req,
                     imem_addr, instr_valid, RESET_PC);
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            tests++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== memf(32'(4 * k)))
            begin
                fails++;
                $display("FAIL zero_wait_stream: valid=%b pc=%h instr=%h, want 1 %h %h",
                         instr_valid, instr_pc, instr, 32'(4 * k), memf(32'(4 * k)));
            end
            tests++;
            if (imem_addr !== 32'(4 * (k + 1))) begin
                fails++;
                $display("FAIL zero_wait_addr: addr=%h, want %h", imem_addr, 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_backpressure();
        int acks = 0;
        mem_rand = 0; mem_lat = 0; instr_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (imem_req && imem_ack) acks++;
        end
        tests++;
        if (acks != DEPTH || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL full_stop: acks=%0d req=%b, want %0d 0", acks, imem_req, DEPTH);
        end
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL full_head: valid=%b pc=%h, want 1 0", instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        cyc();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_pc !== 32'h4) begin
            fails++;
            $display("FAIL full_resume: req=%b addr=%h pc=%h, want 1 10 4", imem_req,
                     imem_addr, instr_pc);
        end
        for (int k = 2; k < 7; k++) begin
            cyc();
            tests++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== memf(32'(4 * k)))
            begin
                fails++;
                $display("FAIL full_drain: valid=%b pc=%h instr=%h, want 1 %h %h", instr_valid,
                         instr_pc, instr, 32'(4 * k), memf(32'(4 * k)));
            end
        end
    endtask

    task automatic test_redirect_mid_req();
        mem_rand = 0; mem_lat = 2; instr_ready = 1'b1;
        do_reset();
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL discard_hold: req=%b addr=%h valid=%b, want 1 0 0", imem_req,
                         imem_addr, instr_valid);
            end
            cyc();
        end
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL discard_next: req=%b addr=%h valid=%b, want 1 100 0", imem_req,
                     imem_addr, instr_valid);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            tests++;
            if (instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL discard_stale: valid=%b, want 0", instr_valid);
            end
        end
        cyc();
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== memf(32'h100)) begin
            fails++;
            $display("FAIL discard_target: valid=%b pc=%h instr=%h, want 1 100 %h",
                     instr_valid, instr_pc, instr, memf(32'h100));
        end
    endtask

    task automatic test_redirect_with_ack();
        mem_rand = 0; mem_lat = 0; instr_ready = 1'b0;
        do_reset();
        cyc(); cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        cyc();
        redirect_valid = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || instr !== NOP || imem_req !== 1'b1 ||
            imem_addr !== 32'h200) begin
            fails++;
            $display("FAIL redir_ack: valid=%b instr=%h req=%b addr=%h, want 0 %h 1 200",
                     instr_valid, instr, imem_req, imem_addr, NOP);
        end
        cyc();
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== memf(32'h200)) begin
            fails++;
            $display("FAIL redir_ack_next: valid=%b pc=%h instr=%h, want 1 200 %h",
                     instr_valid, instr_pc, instr, memf(32'h200));
        end
    endtask

    task automatic test_redirect_with_pop();
        mem_rand = 0; mem_lat = 0; instr_ready = 1'b0;
        do_reset();
        cyc(); cyc(); cyc(); cyc();
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL redir_pop_head: valid=%b pc=%h, want 1 0", instr_valid, instr_pc);
        end
        cyc();
        redirect_valid = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'h0 ||
            imem_addr !== 32'h40) begin
            fails++;
            $display("FAIL redir_pop_flush: valid=%b instr=%h pc=%h addr=%h, want 0 %h 0 40",
                     instr_valid, instr, instr_pc, imem_addr, NOP);
        end
        cyc();
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
            fails++;
            $display("FAIL redir_pop_next: valid=%b pc=%h, want 1 40", instr_valid, instr_pc);
        end
    endtask

    task automatic test_async_reset();
        mem_rand = 0; mem_lat = 0; instr_ready = 1'b0;
        do_reset();
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP) begin
            fails++;
            $display("FAIL async_reset: req=%b valid=%b instr=%h, want 0 0 %h", imem_req,
                     instr_valid, instr, NOP);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            fails++;
            $display("FAIL async_restart: req=%b addr=%h, want 1 %h", imem_req, imem_addr,
                     RESET_PC);
        end
    endtask

    task automatic test_random();
        int thr;
        mem_rand = 1; instr_ready = 1'b0;
        do_reset();
        mq.delete();
        exp_addr  = RESET_PC;
        dead      = 1'b0;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        pops      = 0;
        mon_en    = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            thr = ((i / 100) % 2 == 1) ? 2 : 9;
            instr_ready    = ($urandom_range(0, 9) < thr);
            redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else redirect_pc = $urandom;
            cyc();
        end
        redirect_valid = 1'b0;
        cyc();
        mon_en = 1'b0;
        tests++;
        if (pops < 200) begin
            fails++;
            $display("FAIL random_progress: pops=%0d, want >= 200", pops);
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        #2;
        rst_n = 1'b0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_mid_req();
        test_redirect_with_ack();
        test_redirect_with_pop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits upstream of the single-cycle core and replaces the direct PC-to-instruction-memory path.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to the core over valid/ready.
- Handles branch/jump redirects: flushes the FIFO and drops any in-flight response.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- redirect_valid  input  1  core requests a fetch redirect (taken branch/jump).
- redirect_pc  input  32  new fetch address; bits [1:0] are ignored and forced to 0.
- imem_req  output  1  memory request valid.
- imem_addr  output  32  word-aligned request address.
- imem_ack  input  1  response valid; counted only while imem_req=1; may assert in the same cycle as imem_req.
- imem_rdata  input  32  response instruction; sampled when imem_ack=1.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr_ready  input  1  core accepts the head this cycle.
- instr  output  32  head instruction; 32'h00000013 (NOP) when the FIFO is empty.
- instr_pc  output  32  PC of the head instruction; 0 when empty.

Behaviour:
- Reset (async assert, sync deassert edge): fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, FIFO empty, instr_valid=0, instr=NOP, instr_pc=0, state=IDLE.
- Only one memory request may be outstanding. Issue condition: fifo_count < DEPTH.
- State machine:
  - IDLE: if no redirect and issue condition holds -> REQ, imem_req=1, imem_addr=fetch_pc.
  - REQ: imem_req and imem_addr are held stable until imem_ack.
    - On ack without redirect: push {fetch_pc, imem_rdata}; fetch_pc+=4 (32-bit wrap, 0xFFFFFFFC -> 0). Go to REQ with the new address if fifo_count after push/pop < DEPTH, else IDLE.
    - On redirect without ack: -> DISCARD; imem_req and imem_addr stay stable.
  - DISCARD: keep the request asserted until ack, drop the data, then go to IDLE, or to REQ at fetch_pc (the redirect target).
- Redirect (any state): FIFO flushed at the edge; fetch_pc=redirect_pc&~3.
  - Redirect and ack in the same cycle: the ack data is dropped; next state is IDLE/REQ at the target, with no DISCARD.
  - Redirect in DISCARD: fetch_pc is updated again; the last redirect wins.
- Output handshake: a pop occurs when instr_valid & instr_ready. A pop in the same cycle as a redirect is still a valid transfer; the remaining entries are flushed.
- Simultaneous push and pop: fifo_count is unchanged. Push is never attempted when full, because no request is issued when full.
- Latency: from an issue cycle with same-cycle ack, instr_valid=1 on the next cycle. Sustained throughput with a zero-wait memory and instr_ready held high is 1 instruction/cycle.
- instr_ready while empty has no effect. instr, instr_pc and instr_valid are driven from registered FIFO state only; there is no combinational path from imem_* to instr*.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- When defined, adds two output ports:
  - stall_cycles [31:0]: increments each cycle that instr_valid=0 and rst_n=1.
  - flush_count [31:0]: increments on each cycle with redirect_valid=1.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined, these ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Reset then zero-wait memory (ack same cycle), instr_ready=1 -> imem_addr sequence 0,4,8,...; instr_pc 0,4,8 on consecutive cycles starting 2 cycles after reset release; instr matches memory.
- instr_ready=0 with DEPTH=4 -> exactly 4 acks accepted, then imem_req=0. Raise ready -> entries drain in order and fetch resumes at 0x10.
- 3-cycle-latency memory, redirect_pc=0x100 asserted mid-request -> imem_addr held until ack, data dropped, next request at 0x100, no stale instr_valid.
- Redirect and ack in the same cycle with redirect_pc=0x203 -> ack data dropped, FIFO empty next cycle, next imem_addr=0x200.
- Redirect while instr_valid&instr_ready -> head transferred once, remaining entries gone; instr=0x00000013, instr_valid=0 on the next cycle.
- Assert rst_n=0 asynchronously while in REQ -> imem_req and instr_valid drop immediately without a clock edge. After release, fetch restarts at RESET_PC.
